// File: rtl/pipeline_hazard_ctrl.sv
// Scoreboard stall/flush controller for the in-order RV32I decode stage.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush cycle counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned NUM_REGS     = 32,
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                clk_100MHz,
    input  logic                reset,
    input  logic                i_id_valid,
    input  logic [REG_AW-1:0]   i_id_rs1,
    input  logic [REG_AW-1:0]   i_id_rs2,
    input  logic [REG_AW-1:0]   i_id_rd,
    input  logic                i_id_uses_rs1,
    input  logic                i_id_uses_rs2,
    input  logic                i_id_writes_rd,
    input  logic                i_wb_valid,
    input  logic [REG_AW-1:0]   i_wb_rd,
    input  logic                i_br_taken,
    input  logic                i_ex_busy,
    output logic                o_issue,
    output logic                o_stall_if,
    output logic                o_stall_id,
    output logic                o_flush_id,
    output logic [NUM_REGS-1:0] o_sb_pending,
    output logic                o_sb_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]         o_perf_stall_cnt,
    output logic [31:0]         o_perf_flush_cnt
`endif
);

    localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    // Counter holds the flush cycles still owed after the branch cycle itself.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [NUM_REGS-1:0] r_sb_pending;
    logic                r_sb_err;
    logic [NUM_REGS-1:0] w_set_vec;
    logic [NUM_REGS-1:0] w_clr_vec;
    logic                w_raw;
    logic                w_waw;
    logic                w_hazard;
    logic                w_wb_bad;

    // State register
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic; a branch always (re)arms the flush window
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (i_br_taken) begin
            w_cnt_next   = CNT_LOAD;
            w_state_next = (CNT_LOAD != '0) ? ST_FLUSH : ST_RUN;
        end else if (r_state == ST_FLUSH) begin
            if (r_cnt > CNT_W'(1)) begin
                w_cnt_next = r_cnt - CNT_W'(1);
            end else begin
                w_cnt_next   = '0;
                w_state_next = ST_RUN;
            end
        end
    end

    // Hazard detect against registered scoreboard only; x0 bit is always clear
    assign w_raw    = (i_id_uses_rs1 & r_sb_pending[i_id_rs1]) |
                      (i_id_uses_rs2 & r_sb_pending[i_id_rs2]);
    assign w_waw    = i_id_writes_rd & r_sb_pending[i_id_rd];
    assign w_hazard = i_id_valid & (w_raw | w_waw);

    // Output logic
    always_comb begin
        o_issue    = 1'b0;
        o_stall_if = 1'b0;
        o_stall_id = 1'b0;
        o_flush_id = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_RUN: begin
                    if (i_br_taken) begin
                        o_flush_id = 1'b1;
                    end else begin
                        o_issue    = i_id_valid & ~w_hazard & ~i_ex_busy;
                        o_stall_if = i_id_valid & (w_hazard | i_ex_busy);
                        o_stall_id = i_id_valid & (w_hazard | i_ex_busy);
                    end
                end
                ST_FLUSH: o_flush_id = 1'b1;
                default:  o_flush_id = 1'b0;
            endcase
        end
    end

    assign w_set_vec = (o_issue && i_id_writes_rd && (i_id_rd != '0))
                     ? (NUM_REGS'(1) << i_id_rd) : '0;
    assign w_clr_vec = (i_wb_valid && (i_wb_rd != '0))
                     ? (NUM_REGS'(1) << i_wb_rd) : '0;
    assign w_wb_bad  = i_wb_valid && (i_wb_rd != '0) && !r_sb_pending[i_wb_rd];

    // Scoreboard: set wins over clear on the same register
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_sb_pending <= '0;
            r_sb_err     <= 1'b0;
        end else begin
            r_sb_pending <= (r_sb_pending & ~w_clr_vec) | w_set_vec;
            if (w_wb_bad) begin
                r_sb_err <= 1'b1;
            end
        end
    end

    assign o_sb_pending = r_sb_pending;
    assign o_sb_err     = r_sb_err;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_perf_stall_cnt;
    logic [31:0] r_perf_flush_cnt;

    // Saturating event counters
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_perf_stall_cnt <= '0;
            r_perf_flush_cnt <= '0;
        end else begin
            if (o_stall_id && (r_perf_stall_cnt != '1)) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            end
            if (o_flush_id && (r_perf_flush_cnt != '1)) begin
                r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
            end
        end
    end

    assign o_perf_stall_cnt = r_perf_stall_cnt;
    assign o_perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (FLUSH_CYCLES=2).
// Perf counter checks compile only with HAZARD_PERF_CNT_EN.
module tb_pipeline_hazard_ctrl;

    logic        clk_100MHz;
    logic        reset;
    logic        i_id_valid;
    logic [4:0]  i_id_rs1;
    logic [4:0]  i_id_rs2;
    logic [4:0]  i_id_rd;
    logic        i_id_uses_rs1;
    logic        i_id_uses_rs2;
    logic        i_id_writes_rd;
    logic        i_wb_valid;
    logic [4:0]  i_wb_rd;
    logic        i_br_taken;
    logic        i_ex_busy;
    logic        o_issue;
    logic        o_stall_if;
    logic        o_stall_id;
    logic        o_flush_id;
    logic [31:0] o_sb_pending;
    logic        o_sb_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] o_perf_stall_cnt;
    logic [31:0] o_perf_flush_cnt;
`endif

    int n_checks  = 0;
    int n_errors  = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    pipeline_hazard_ctrl #(
        .NUM_REGS    (32),
        .REG_AW      (5),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk_100MHz    (clk_100MHz),
        .reset         (reset),
        .i_id_valid    (i_id_valid),
        .i_id_rs1      (i_id_rs1),
        .i_id_rs2      (i_id_rs2),
        .i_id_rd       (i_id_rd),
        .i_id_uses_rs1 (i_id_uses_rs1),
        .i_id_uses_rs2 (i_id_uses_rs2),
        .i_id_writes_rd(i_id_writes_rd),
        .i_wb_valid    (i_wb_valid),
        .i_wb_rd       (i_wb_rd),
        .i_br_taken    (i_br_taken),
        .i_ex_busy     (i_ex_busy),
        .o_issue       (o_issue),
        .o_stall_if    (o_stall_if),
        .o_stall_id    (o_stall_id),
        .o_flush_id    (o_flush_id),
        .o_sb_pending  (o_sb_pending),
        .o_sb_err      (o_sb_err)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .o_perf_stall_cnt(o_perf_stall_cnt),
        .o_perf_flush_cnt(o_perf_flush_cnt)
`endif
    );

    initial begin
        clk_100MHz = 1'b0;
        forever #5 clk_100MHz = ~clk_100MHz;
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic u1, input logic u2, input logic wr);
        i_id_valid     = v;
        i_id_rs1       = rs1;
        i_id_rs2       = rs2;
        i_id_rd        = rd;
        i_id_uses_rs1  = u1;
        i_id_uses_rs2  = u2;
        i_id_writes_rd = wr;
    endtask

    // Called 1ns after a rising edge with inputs applied; checks the
    // combinational outputs, then advances to 1ns after the next edge.
    task automatic cyc(input string tag, input logic ei, input logic es, input logic ef);
        #1;
        check1({tag, ".issue"},    o_issue,    ei);
        check1({tag, ".stall_if"}, o_stall_if, es);
        check1({tag, ".stall_id"}, o_stall_id, es);
        check1({tag, ".flush_id"}, o_flush_id, ef);
        if (es) exp_stall++;
        if (ef) exp_flush++;
        @(posedge clk_100MHz);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        i_wb_valid = 1'b0;
        i_wb_rd    = 5'd0;
        i_br_taken = 1'b1;
        i_ex_busy  = 1'b0;
        set_id(1'b1, 5'd3, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1);

        // Reset forces all control outputs low even with live inputs
        repeat (2) @(posedge clk_100MHz);
        #1;
        check1("rst.issue",    o_issue,    1'b0);
        check1("rst.stall_id", o_stall_id, 1'b0);
        check1("rst.flush_id", o_flush_id, 1'b0);
        check32("rst.pending", o_sb_pending, 32'h0);
        check1("rst.sb_err",   o_sb_err,   1'b0);
        i_br_taken = 1'b0;
        reset      = 1'b0;

        // Issue writer of x5
        cyc("issue_x5", 1'b1, 1'b0, 1'b0);
        check32("pend_x5", o_sb_pending, 32'h0000_0020);

        // RAW on rs2=x5, released one cycle after writeback
        set_id(1'b1, 5'd0, 5'd5, 5'd6, 1'b0, 1'b1, 1'b1);
        cyc("raw_rs2", 1'b0, 1'b1, 1'b0);
        check32("pend_raw_hold", o_sb_pending, 32'h0000_0020);
        i_wb_valid = 1'b1;
        i_wb_rd    = 5'd5;
        cyc("raw_wb_same", 1'b0, 1'b1, 1'b0);
        i_wb_valid = 1'b0;
        check32("pend_x5_cleared", o_sb_pending, 32'h0);
        cyc("raw_release", 1'b1, 1'b0, 1'b0);
        check32("pend_x6", o_sb_pending, 32'h0000_0040);

        // rd=x0 and rs1=x0 are untracked
        set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
        cyc("rd_x0", 1'b1, 1'b0, 1'b0);
        check32("pend_after_x0", o_sb_pending, 32'h0000_0040);

        // WAW on x6; invalid instruction never stalls
        set_id(1'b1, 5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b1);
        cyc("waw", 1'b0, 1'b1, 1'b0);
        set_id(1'b0, 5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b1);
        cyc("waw_invalid", 1'b0, 1'b0, 1'b0);
        check32("pend_waw_hold", o_sb_pending, 32'h0000_0040);
        i_wb_valid = 1'b1;
        i_wb_rd    = 5'd6;
        cyc("wb_x6", 1'b0, 1'b0, 1'b0);
        i_wb_valid = 1'b0;
        check32("pend_x6_cleared", o_sb_pending, 32'h0);

        // Taken branch: two flush cycles, flushed writer does not set x8
        set_id(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b1, 1'b1);
        i_br_taken = 1'b1;
        cyc("br_run", 1'b0, 1'b0, 1'b1);
        i_br_taken = 1'b0;
        check32("pend_br_flushed", o_sb_pending, 32'h0);
        cyc("br_flush2", 1'b0, 1'b0, 1'b1);
        check32("pend_br_flushed2", o_sb_pending, 32'h0);
        cyc("br_done", 1'b1, 1'b0, 1'b0);
        check32("pend_x8", o_sb_pending, 32'h0000_0100);

        // Second branch inside the flush window extends it; hazard ignored in FLUSH
        set_id(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        i_br_taken = 1'b1;
        cyc("br2_c1", 1'b0, 1'b0, 1'b1);
        set_id(1'b1, 5'd8, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        cyc("br2_c2", 1'b0, 1'b0, 1'b1);
        i_br_taken = 1'b0;
        cyc("br2_c3", 1'b0, 1'b0, 1'b1);
        set_id(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        cyc("br2_end", 1'b1, 1'b0, 1'b0);

        // ex_busy stalls a clean instruction for 3 cycles
        i_ex_busy = 1'b1;
        cyc("busy1", 1'b0, 1'b1, 1'b0);
        cyc("busy2", 1'b0, 1'b1, 1'b0);
        cyc("busy3", 1'b0, 1'b1, 1'b0);
        i_ex_busy = 1'b0;
        cyc("busy_end", 1'b1, 1'b0, 1'b0);

        // Branch overrides ex_busy
        i_ex_busy  = 1'b1;
        i_br_taken = 1'b1;
        cyc("busy_br", 1'b0, 1'b0, 1'b1);
        i_br_taken = 1'b0;
        cyc("busy_flush", 1'b0, 1'b0, 1'b1);
        i_ex_busy = 1'b0;
        cyc("busy_br_end", 1'b1, 1'b0, 1'b0);

        // Writeback to non-pending x7 sets sticky error
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        i_wb_valid = 1'b1;
        i_wb_rd    = 5'd7;
        cyc("wb_x7", 1'b0, 1'b0, 1'b0);
        check1("err_set", o_sb_err, 1'b1);
        check32("pend_after_bad_wb", o_sb_pending, 32'h0000_0100);
        i_wb_rd = 5'd8;
        cyc("wb_x8", 1'b0, 1'b0, 1'b0);
        i_wb_valid = 1'b0;
        check32("pend_x8_cleared", o_sb_pending, 32'h0);
        cyc("idle", 1'b0, 1'b0, 1'b0);
        check1("err_sticky", o_sb_err, 1'b1);

`ifdef HAZARD_PERF_CNT_EN
        check32("perf_stall", o_perf_stall_cnt, 32'(exp_stall));
        check32("perf_flush", o_perf_flush_cnt, 32'(exp_flush));
`endif

        // Reset clears the sticky error
        reset = 1'b1;
        @(posedge clk_100MHz);
        #1;
        check1("rst2.sb_err", o_sb_err, 1'b0);
        check32("rst2.pending", o_sb_pending, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
